// File: rtl/note_scroller_if.sv
// Chart-source handshake into the note scroller: the source offers a lane,
// and the scroller takes it on any cycle where valid and ready are both high.
interface note_scroller_if;
    logic       note_valid;
    logic [2:0] note_lane;
    logic       note_ready;

    modport master (output note_valid, output note_lane, input note_ready);
    modport slave  (input note_valid, input note_lane, output note_ready);
endinterface

// File: rtl/note_scroller.sv
// Rhythm-game note field: eight lanes scroll down seven rows on a prescaled tick.
// Key presses that land on the bottom row count as hits; notes that fall off it count as misses.
module note_scroller #(
    parameter int TICK_DIV = 2500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    note_scroller_if.slave   note_if,
    input  logic [7:0]       key,
    output logic [191:0]     notesMap0,
    output logic [191:0]     notesMap1,
    output logic [191:0]     notesMap2,
    output logic [191:0]     notesMap3,
    output logic [191:0]     notesMap4,
    output logic [191:0]     notesMap5,
    output logic [191:0]     notesMap6,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic [9:0]       hit_count,
    output logic [9:0]       miss_count
);
    localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [6:0][7:0] occ_q, occ_d;
    logic [7:0]      pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      ks1_q, ks1_d, ks2_q, ks2_d, kprev_q, kprev_d;
    logic            hit_pulse_q, hit_pulse_d, miss_pulse_q, miss_pulse_d;
    logic [9:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    logic            tick;
    logic [7:0]      acc_mask, key_edge, hit_mask, miss_mask;
    logic [191:0]    pix [7];

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] c, input logic [3:0] n);
        logic [10:0] s;
        s = {1'b0, c} + {7'b0, n};
        return (s > 11'd999) ? 10'd999 : s[9:0];
    endfunction

    assign note_if.note_ready = run;
    assign tick      = run && (cnt_q == CNT_MAX);
    assign acc_mask  = (run && note_if.note_valid) ? (8'd1 << note_if.note_lane) : 8'd0;
    assign key_edge  = ks2_q & ~kprev_q;
    // Hits are judged against the bottom row as it stood before any shift this cycle.
    assign hit_mask  = key_edge & occ_q[6];
    assign miss_mask = tick ? (occ_q[6] & ~hit_mask) : 8'd0;

    always_comb begin
        occ_d        = occ_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        ks1_d        = key;
        ks2_d        = ks1_q;
        kprev_d      = ks2_q;
        hit_pulse_d  = |hit_mask;
        miss_pulse_d = |miss_mask;
        hit_cnt_d    = sat_add(hit_cnt_q, popcount8(hit_mask));
        miss_cnt_d   = sat_add(miss_cnt_q, popcount8(miss_mask));

        if (!run) begin
            occ_d        = '0;
            pend_d       = '0;
            cnt_d        = '0;
            hit_pulse_d  = 1'b0;
            miss_pulse_d = 1'b0;
        end else if (tick) begin
            // A hit lane on the bottom row simply falls off with the shift.
            for (int r = 6; r > 0; r--) occ_d[r] = occ_q[r-1];
            occ_d[0] = pend_q | acc_mask;
            pend_d   = '0;
            cnt_d    = '0;
        end else begin
            occ_d[6] = occ_q[6] & ~hit_mask;
            pend_d   = pend_q | acc_mask;
            cnt_d    = cnt_q + CW'(1);
        end

        if (clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q        <= '0;
            pend_q       <= '0;
            cnt_q        <= '0;
            ks1_q        <= '0;
            ks2_q        <= '0;
            kprev_q      <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            occ_q        <= occ_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            ks1_q        <= ks1_d;
            ks2_q        <= ks2_d;
            kprev_q      <= kprev_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Each lane is an 8-column strip with a dark column either side of the note.
    for (genvar gi = 0; gi < 7; gi++) begin : g_row
        for (genvar gj = 0; gj < 8; gj++) begin : g_lane
            localparam logic [2:0] COLOUR = 3'((gj % 7) + 1);
            assign pix[gi][24*gj +: 24] = occ_q[gi][gj] ? {3'b000, {6{COLOUR}}, 3'b000} : 24'd0;
        end
    end

    assign notesMap0  = pix[0];
    assign notesMap1  = pix[1];
    assign notesMap2  = pix[2];
    assign notesMap3  = pix[3];
    assign notesMap4  = pix[4];
    assign notesMap5  = pix[5];
    assign notesMap6  = pix[6];
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_note_scroller.sv
// Self-checking bench for note_scroller with a four-cycle tick: scrolling, hits,
// misses, hit-on-tick, saturation, clear, run-low clearing and asynchronous reset.
module tb_note_scroller;
    localparam int TD = 4;

    typedef logic [6:0][7:0] frame_t;
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] m;
    } cnt_t;

    logic         clk = 1'b0;
    logic         rst, run, clr;
    logic [7:0]   key;
    logic [191:0] notesMap0, notesMap1, notesMap2, notesMap3, notesMap4, notesMap5, notesMap6;
    logic         hit_pulse, miss_pulse;
    logic [9:0]   hit_count, miss_count;

    note_scroller_if nif();

    note_scroller #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .run(run), .clr(clr), .note_if(nif), .key(key),
        .notesMap0(notesMap0), .notesMap1(notesMap1), .notesMap2(notesMap2),
        .notesMap3(notesMap3), .notesMap4(notesMap4), .notesMap5(notesMap5),
        .notesMap6(notesMap6), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     rc = 0;
    int     exp_hits = 0;
    int     exp_miss = 0;
    frame_t fq[$];
    cnt_t   cq[$];

    function automatic logic [191:0] row(input int r);
        case (r)
            0: return notesMap0;
            1: return notesMap1;
            2: return notesMap2;
            3: return notesMap3;
            4: return notesMap4;
            5: return notesMap5;
            6: return notesMap6;
            default: return '0;
        endcase
    endfunction

    function automatic logic [191:0] pat(input logic [7:0] m);
        logic [191:0] v;
        v = '0;
        for (int l = 0; l < 8; l++)
            if (m[l])
                for (int k = 1; k <= 6; k++) v[3*(8*l+k) +: 3] = 3'((l % 7) + 1);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        if (run) rc++;
        else rc = 0;
        #1;
    endtask

    task automatic adv_to(input int n);
        for (int i = 0; i < 400 && rc < n; i++) step();
    endtask

    task automatic restart();
        run = 1'b0;
        step();
        run = 1'b1;
    endtask

    task automatic accept(input int lane);
        nif.note_valid = 1'b1;
        nif.note_lane  = 3'(lane);
        step();
        nif.note_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; clr = 1'b0; key = '0;
        nif.note_valid = 1'b0; nif.note_lane = '0;
        #12;
        for (int r = 0; r < 7; r++) begin
            checks++;
            if (row(r) !== '0) begin
                errors++; $display("FAIL reset_row%0d got %h want 0", r, row(r));
            end
        end
        checks++;
        if (hit_count !== 10'd0 || miss_count !== 10'd0) begin
            errors++; $display("FAIL reset_counts got hit=%0d miss=%0d want 0 0", hit_count, miss_count);
        end
        checks++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || nif.note_ready !== 1'b0) begin
            errors++; $display("FAIL reset_flags got hp=%b mp=%b rdy=%b want 0 0 0", hit_pulse, miss_pulse, nif.note_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_scroll();
        frame_t f;
        cnt_t   c;
        restart();
        checks++;
        if (nif.note_ready !== 1'b1) begin
            errors++; $display("FAIL scroll_ready got %b want 1", nif.note_ready);
        end
        nif.note_valid = 1'b1; nif.note_lane = 3'd2;
        step(); step();
        nif.note_valid = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            f = '0; f[t-1] = 8'h04; fq.push_back(f);
        end
        for (int t = 1; t <= 7; t++) begin
            adv_to(TD * t);
            f = fq.pop_front();
            for (int r = 0; r < 7; r++) begin
                checks++;
                if (row(r) !== pat(f[r])) begin
                    errors++; $display("FAIL scroll_t%0d_row%0d got %h want %h", t, r, row(r), pat(f[r]));
                end
            end
            $display("scroll tick %0d checked", t);
        end
        exp_miss++; cq.push_back('{h: 10'(exp_hits), m: 10'(exp_miss)});
        adv_to(TD * 8);
        c = cq.pop_front();
        checks++;
        if (miss_pulse !== 1'b1 || miss_count !== c.m) begin
            errors++; $display("FAIL scroll_miss got mp=%b miss=%0d want 1 %0d", miss_pulse, miss_count, c.m);
        end
        checks++;
        if ((notesMap0 | notesMap1 | notesMap2 | notesMap3 | notesMap4 | notesMap5 | notesMap6) !== '0) begin
            errors++; $display("FAIL scroll_empty got nonzero field want 0");
        end
        step();
        checks++;
        if (miss_pulse !== 1'b0) begin
            errors++; $display("FAIL scroll_miss_once got %b want 0", miss_pulse);
        end
    endtask

    task automatic test_hit();
        cnt_t c;
        restart();
        accept(2);
        adv_to(28);
        key = 8'h04;
        exp_hits++; cq.push_back('{h: 10'(exp_hits), m: 10'(exp_miss)});
        step(); step();
        checks++;
        if (hit_pulse !== 1'b0) begin
            errors++; $display("FAIL hit_early got %b want 0", hit_pulse);
        end
        step();
        c = cq.pop_front();
        checks++;
        if (hit_pulse !== 1'b1 || hit_count !== c.h || notesMap6 !== '0) begin
            errors++; $display("FAIL hit_lane2 got hp=%b hit=%0d row6=%h want 1 %0d 0", hit_pulse, hit_count, c.h, notesMap6);
        end
        key = '0;
        step();
        checks++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || miss_count !== 10'(exp_miss)) begin
            errors++; $display("FAIL hit_nomiss got hp=%b mp=%b miss=%0d want 0 0 %0d", hit_pulse, miss_pulse, miss_count, exp_miss);
        end
        $display("test_hit hit_count=%0d", hit_count);
    endtask

    task automatic test_multi();
        cnt_t c;
        restart();
        accept(0); accept(7);
        adv_to(4);
        accept(1); accept(3); accept(5);
        adv_to(28);
        checks++;
        if (notesMap6 !== pat(8'h81)) begin
            errors++; $display("FAIL multi_row6 got %h want %h", notesMap6, pat(8'h81));
        end
        exp_miss += 2; cq.push_back('{h: 10'(exp_hits), m: 10'(exp_miss)});
        adv_to(32);
        c = cq.pop_front();
        checks++;
        if (miss_pulse !== 1'b1 || miss_count !== c.m || notesMap6 !== pat(8'h2A)) begin
            errors++; $display("FAIL multi_miss got mp=%b miss=%0d row6=%h want 1 %0d %h", miss_pulse, miss_count, notesMap6, c.m, pat(8'h2A));
        end
        key = 8'h2A;
        exp_hits += 3; cq.push_back('{h: 10'(exp_hits), m: 10'(exp_miss)});
        step();
        checks++;
        if (miss_pulse !== 1'b0) begin
            errors++; $display("FAIL multi_miss_once got %b want 0", miss_pulse);
        end
        step(); step();
        c = cq.pop_front();
        checks++;
        if (hit_pulse !== 1'b1 || hit_count !== c.h) begin
            errors++; $display("FAIL multi_hit got hp=%b hit=%0d want 1 %0d", hit_pulse, hit_count, c.h);
        end
        key = '0;
        step();
        checks++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || miss_count !== 10'(exp_miss)) begin
            errors++; $display("FAIL multi_after got hp=%b mp=%b miss=%0d want 0 0 %0d", hit_pulse, miss_pulse, miss_count, exp_miss);
        end
        $display("test_multi hit=%0d miss=%0d", hit_count, miss_count);
    endtask

    task automatic test_hit_on_tick();
        cnt_t c;
        restart();
        accept(0);
        adv_to(4);
        accept(4);
        adv_to(29);
        key = 8'h01;
        exp_hits++; cq.push_back('{h: 10'(exp_hits), m: 10'(exp_miss)});
        step(); step(); step();
        c = cq.pop_front();
        checks++;
        if (hit_pulse !== 1'b1 || hit_count !== c.h) begin
            errors++; $display("FAIL tickhit_hit got hp=%b hit=%0d want 1 %0d", hit_pulse, hit_count, c.h);
        end
        checks++;
        if (miss_pulse !== 1'b0 || miss_count !== c.m) begin
            errors++; $display("FAIL tickhit_miss got mp=%b miss=%0d want 0 %0d", miss_pulse, miss_count, c.m);
        end
        checks++;
        if (notesMap6 !== pat(8'h10) || notesMap5 !== '0) begin
            errors++; $display("FAIL tickhit_shift got row6=%h row5=%h want %h 0", notesMap6, notesMap5, pat(8'h10));
        end
        key = '0;
        $display("test_hit_on_tick done");
    endtask

    task automatic test_run_low();
        restart();
        accept(3);
        adv_to(8);
        checks++;
        if (notesMap1 !== pat(8'h08)) begin
            errors++; $display("FAIL runlow_pre got %h want %h", notesMap1, pat(8'h08));
        end
        run = 1'b0;
        step();
        for (int r = 0; r < 7; r++) begin
            checks++;
            if (row(r) !== '0) begin
                errors++; $display("FAIL runlow_row%0d got %h want 0", r, row(r));
            end
        end
        checks++;
        if (hit_count !== 10'(exp_hits) || miss_count !== 10'(exp_miss) || nif.note_ready !== 1'b0) begin
            errors++; $display("FAIL runlow_counts got hit=%0d miss=%0d rdy=%b want %0d %0d 0", hit_count, miss_count, nif.note_ready, exp_hits, exp_miss);
        end
        step(); step();
        run = 1'b1;
        accept(6);
        adv_to(3);
        checks++;
        if (notesMap0 !== '0) begin
            errors++; $display("FAIL restart_early got %h want 0", notesMap0);
        end
        step();
        checks++;
        if (notesMap0 !== pat(8'h40)) begin
            errors++; $display("FAIL restart_tick got %h want %h", notesMap0, pat(8'h40));
        end
        $display("test_run_low done");
    endtask

    task automatic test_async_rst();
        accept(5);
        #2 rst = 1'b1;
        #1;
        for (int r = 0; r < 7; r++) begin
            checks++;
            if (row(r) !== '0) begin
                errors++; $display("FAIL arst_row%0d got %h want 0", r, row(r));
            end
        end
        checks++;
        if (hit_count !== 10'd0 || miss_count !== 10'd0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            errors++; $display("FAIL arst_outputs got hit=%0d miss=%0d hp=%b mp=%b want 0 0 0 0", hit_count, miss_count, hit_pulse, miss_pulse);
        end
        rst = 1'b0;
        rc = 0; exp_hits = 0; exp_miss = 0;
        adv_to(4);
        checks++;
        if ((notesMap0 | notesMap1 | notesMap2 | notesMap3 | notesMap4 | notesMap5 | notesMap6) !== '0) begin
            errors++; $display("FAIL arst_pending got row0=%h want 0", notesMap0);
        end
        $display("test_async_rst done");
    endtask

    task automatic test_saturate_clr();
        cnt_t c;
        restart();
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_hits = 0; exp_miss = 0;
        adv_to(4);
        for (int i = 0; i < 1009; i++) begin
            for (int s = 0; s < TD; s++) begin
                nif.note_valid = (s == 0) && (i < 999);
                nif.note_lane  = 3'(i % 8);
                key = (key == 8'h00) ? 8'hFF : 8'h00;
                step();
            end
        end
        nif.note_valid = 1'b0;
        exp_hits = 999;
        checks++;
        if (hit_count !== 10'(exp_hits) || miss_count !== 10'(exp_miss)) begin
            errors++; $display("FAIL sat_preload got hit=%0d miss=%0d want %0d %0d", hit_count, miss_count, exp_hits, exp_miss);
        end
        for (int i = 0; i < 10; i++) begin
            for (int s = 0; s < TD; s++) begin
                nif.note_valid = (s == 0) && (i == 0);
                key = (key == 8'h00) ? 8'hFF : 8'h00;
                step();
            end
        end
        nif.note_valid = 1'b0;
        checks++;
        if (hit_count !== 10'd999 || miss_count !== 10'(exp_miss)) begin
            errors++; $display("FAIL sat_hold got hit=%0d miss=%0d want 999 %0d", hit_count, miss_count, exp_miss);
        end
        key = '0;
        step(); step(); step();
        restart();
        accept(0);
        adv_to(29);
        key = 8'h01;
        step(); step();
        clr = 1'b1;
        exp_hits = 0; exp_miss = 0; cq.push_back('{h: 10'd0, m: 10'd0});
        step();
        clr = 1'b0;
        c = cq.pop_front();
        checks++;
        if (hit_count !== c.h || miss_count !== c.m || hit_pulse !== 1'b1) begin
            errors++; $display("FAIL clr_priority got hit=%0d miss=%0d hp=%b want %0d %0d 1", hit_count, miss_count, hit_pulse, c.h, c.m);
        end
        key = '0;
        $display("test_saturate_clr done");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scroll();
        test_hit();
        test_multi();
        test_hit_on_tick();
        test_run_low();
        test_async_rst();
        test_saturate_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_scroller.md
NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 Parameter TICK_DIV, default 2500000, clk cycles per scroll tick.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run  input  1  high while game is in PLAY; low = block idle and cleared.
REQ-005 clr  input  1  synchronous clear of hit_count/miss_count.
REQ-006 note_valid  input  1  chart source offers a note.
REQ-007 note_lane  input  3  lane (0-7) of offered note.
REQ-008 note_ready  output  1  equals run; note accepted when note_valid & note_ready.
REQ-009 key  input  8  raw asynchronous lane buttons, active-high.
REQ-010 notesMap0..notesMap6  output  192 each  pixel rows, row 0 = top, row 6 = hit row; column c uses bits [3c+2]=R, [3c+1]=G, [3c]=B.
REQ-011 hit_pulse  output  1  one-cycle pulse per cycle with >=1 hit.
REQ-012 miss_pulse  output  1  one-cycle pulse per tick with >=1 miss.
REQ-013 hit_count  output  10  total hits, saturating.
REQ-014 miss_count  output  10  total misses, saturating.

Function
REQ-015 Note state SHALL be a 7x8 occupancy array occ[row][lane] plus an 8-bit pending mask.
REQ-016 Pixel decode SHALL be combinational from occ: lane l covers columns 8l..8l+7; columns 8l+1..8l+6 show colour ((l mod 7)+1) as {R,G,B} when occ set; columns 8l, 8l+7 and unset lanes are 000.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 while run=1; tick is a one-cycle strobe when count = TICK_DIV-1, then count wraps to 0.
REQ-018 Accept SHALL set pending[note_lane]; repeated accepts to the same lane before a tick merge into one note.
REQ-019 On tick: occ[r] <= occ[r-1] for r=1..6; occ[0] <= pending | accept-this-cycle mask; pending <= 0 (accepts coincident with tick enter row 0, not pending).
REQ-020 key SHALL pass a 2-flop synchroniser then rising-edge detect against the previous synchronised value; edge for lane l = ks2[l] & ~kprev[l].
REQ-021 Hit: edge on lane l while occ[6][l]=1 (pre-shift value) SHALL clear occ[6][l] and count one hit; edges on empty lanes are ignored (no penalty).
REQ-022 Multiple simultaneous hits SHALL add their popcount to hit_count in one cycle; hit_pulse asserts one cycle after the edge-detect cycle, i.e. on the 3rd clk edge after key is sampled high.
REQ-023 Miss: on tick, every lane with occ[6][l]=1 not hit in that same cycle SHALL add one to miss_count; miss_pulse high the cycle after the tick if the count was >0.
REQ-024 Hit and tick in the same cycle: the hit lane counts as hit, never as miss; the shift still occurs.
REQ-025 hit_count and miss_count SHALL saturate at 999; clr zeroes both and has priority over same-cycle increments.
REQ-026 run=0 SHALL synchronously clear occ, pending, prescaler and pulses; counts hold; key synchroniser keeps running.
REQ-027 run rising SHALL restart prescaler from 0; first tick TICK_DIV cycles later.

Reset
REQ-028 rst SHALL clear occ, pending, prescaler, synchroniser flops, hit_pulse, miss_pulse, hit_count, miss_count to 0; all notesMap outputs read 0.
REQ-029 rst asserted mid-operation SHALL take effect immediately, regardless of clk, and discard in-flight notes and pending accepts.

Verification (TICK_DIV=4)
REQ-030 Accept lane 2, run=1 -> after next tick notesMap0 bits for columns 17..22 = 011, all else 0; reaches notesMap6 after 7 ticks.
REQ-031 Lane 2 note in row 6, key[2] pulse -> hit_count 0->1, hit_pulse one cycle, notesMap6 clears, no miss on next tick.
REQ-032 Lanes 0 and 7 in row 6, no keys, tick -> miss_count +2, single miss_pulse.
REQ-033 key[0] edge on tick cycle with lane 0 in row 6 -> hit +1, miss +0, row 5 content moves to row 6.
REQ-034 hit_count preloaded to 999 via 999 hits, one more hit -> stays 999; clr with coincident hit -> 0.
REQ-035 rst pulse between clk edges mid-scroll -> all outputs 0 immediately; run low -> notesMap all 0, counts unchanged.
